// File: rtl/result_fifo.sv
// result_fifo
//   Captures {s, y} from an upstream stage on each falling edge of its busy
//   flag b and queues it for a consumer. Reads are registered (no
//   fall-through): an accepted read presents the entry on rd_data at the
//   next edge with a one-cycle rd_valid pulse.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous reset, active high
//   y, s      upstream result / status, sampled on the capture cycle
//   b         upstream busy; high->low marks a completed result
//   rd_en     consumer read request
//   rd_data   {s, y} of the entry popped by the last accepted read
//   rd_valid  one-cycle pulse qualifying rd_data
//   empty     count == 0
//   full      count == DEPTH
//   count     stored entries
//   overflow  sticky: a result was dropped because the FIFO was full
//   max_y     largest accepted y since reset
module result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               y,
  input  logic [2:0]               s,
  input  logic                     b,
  input  logic                     rd_en,
  output logic [10:0]              rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               max_y
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("result_fifo: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [2:0] s;
    logic [7:0] y;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            b_prev_q;
  logic            rd_valid_q, rd_valid_d;
  logic            overflow_q, overflow_d;
  entry_t          rd_data_q, rd_data_d;
  logic [7:0]      max_y_q, max_y_d;

  logic            is_empty, is_full, cap, rd_acc, wr_acc;

  always_comb begin
    is_empty   = (count_q == '0);
    is_full    = (count_q == CW'(DEPTH));
    cap        = b_prev_q & ~b;
    rd_acc     = rd_en & ~is_empty;
    // A read in the same cycle frees a slot, so a capture at full still lands.
    wr_acc     = cap & (~is_full | rd_acc);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = rd_acc;
    rd_data_d  = rd_data_q;
    overflow_d = overflow_q;
    max_y_d    = max_y_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (cap && !wr_acc) overflow_d = 1'b1;
    if (wr_acc && (y > max_y_q)) max_y_d = y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      b_prev_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
      max_y_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      b_prev_q   <= b;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      overflow_q <= overflow_d;
      max_y_q    <= max_y_d;
    end
  end

  // Storage is not reset; entries are only read once count says they exist.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= {s, y};
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign max_y    = max_y_q;

endmodule

// File: tb/tb_result_fifo.sv
// Directed bench for result_fifo (DEPTH = 4). Inputs change 1 ns after the
// rising edge and outputs are sampled at the same point.
module tb_result_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  y;
  logic [2:0]  s;
  logic        b;
  logic        rd_en;
  logic [10:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        overflow;
  logic [7:0]  max_y;

  int n_checks = 0;
  int n_err    = 0;

  result_fifo #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .y(y), .s(s), .b(b), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .max_y(max_y)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // b high for one edge, then low: the second edge is the capture.
  task automatic capture(input logic [7:0] yv, input logic [2:0] sv);
    y = yv; s = sv; b = 1'b1;
    tick();
    b = 1'b0;
    tick();
  endtask

  // One-cycle read request; checks the popped entry on the following cycle.
  task automatic read_chk(input string tag, input logic [10:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({tag, "_vld"}, rd_valid, 1);
    chk({tag, "_dat"}, rd_data, exp);
    tick();
    chk({tag, "_vld_drop"}, rd_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; y = '0; s = '0; b = 1'b0; rd_en = 1'b0;
    tick();
    tick();
    // reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_vld", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_maxy", max_y, 0);
    rst = 1'b0;

    // single capture and read
    capture(8'd5, 3'd3);
    chk("one_count", count, 1);
    chk("one_empty", empty, 0);
    read_chk("one_rd", 11'h305);
    chk("one_empty_after", empty, 1);

    // fill, overflow, drain
    capture(8'd10, 3'd1);
    capture(8'd20, 3'd2);
    capture(8'd30, 3'd3);
    capture(8'd40, 3'd4);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    chk("fill_ovf0", overflow, 0);
    capture(8'd50, 3'd5);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    chk("ovf_maxy", max_y, 40);
    read_chk("drain0", 11'h10A);
    read_chk("drain1", 11'h214);
    read_chk("drain2", 11'h31E);
    read_chk("drain3", 11'h428);
    chk("drain_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);

    // capture and read together while full
    do_reset();
    chk("rst2_ovf", overflow, 0);
    capture(8'd1, 3'd0);
    capture(8'd2, 3'd0);
    capture(8'd3, 3'd0);
    capture(8'd4, 3'd0);
    y = 8'd99; s = 3'd0; b = 1'b1;
    tick();
    b = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("sim_count", count, 4);
    chk("sim_ovf", overflow, 0);
    chk("sim_vld", rd_valid, 1);
    chk("sim_dat", rd_data, 11'h001);
    chk("sim_maxy", max_y, 99);
    tick();
    read_chk("sim_rd2", 11'h002);
    read_chk("sim_rd3", 11'h003);
    read_chk("sim_rd4", 11'h004);
    read_chk("sim_rd99", 11'h063);

    // reads while empty, capture in the third cycle
    rd_en = 1'b1; b = 1'b0;
    tick();
    chk("er1_vld", rd_valid, 0);
    chk("er1_dat", rd_data, 11'h063);
    b = 1'b1; y = 8'd7; s = 3'd2;
    tick();
    chk("er2_vld", rd_valid, 0);
    chk("er2_count", count, 0);
    b = 1'b0;
    tick();
    rd_en = 1'b0;
    chk("er3_vld", rd_valid, 0);
    chk("er3_count", count, 1);
    chk("er3_dat", rd_data, 11'h063);
    tick();
    chk("er4_vld", rd_valid, 0);
    read_chk("er_rd", 11'h207);

    // wrap-around with interleaved capture/read
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      capture(8'(i), 3'(i % 8));
      chk("wrap_cnt", count, 1);
      read_chk("wrap_rd", {3'(i % 8), 8'(i)});
      chk("wrap_empty", empty, 1);
    end
    chk("wrap_maxy", max_y, 10);

    // mid-operation asynchronous reset
    capture(8'd11, 3'd1);
    capture(8'd12, 3'd1);
    capture(8'd13, 3'd1);
    capture(8'd14, 3'd1);
    capture(8'd15, 3'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("mid_pre_count", count, 3);
    chk("mid_pre_ovf", overflow, 1);
    b = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("mid_count", count, 0);
    chk("mid_empty", empty, 1);
    chk("mid_full", full, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_maxy", max_y, 0);
    chk("mid_vld", rd_valid, 0);
    chk("mid_dat", rd_data, 0);
    #2 rst = 1'b0;
    // b was high through reset: only its next fall captures
    tick();
    chk("post_vld", rd_valid, 0);
    chk("post_count0", count, 0);
    y = 8'd33; s = 3'd6; b = 1'b0;
    tick();
    chk("post_count1", count, 1);
    read_chk("post_rd", 11'h621);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/result_fifo.md
RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 Parameter DEPTH, default 4, is the number of FIFO entries and SHALL be a power of two, 2 or greater.
REQ-002 Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit, is the asynchronous, active-high reset.
REQ-004 Port y, input, 8 bits, is the result value from the upstream computation stage.
REQ-005 Port s, input, 3 bits, is the status/step code from the upstream stage, captured alongside y.
REQ-006 Port b, input, 1 bit, is the upstream busy flag; its falling edge marks a completed result.
REQ-007 Port rd_en, input, 1 bit, is the read request from the consumer.
REQ-008 Port rd_data, output, 11 bits, carries {s, y} of the entry popped by the last accepted read.
REQ-009 Port rd_valid, output, 1 bit, is a one-cycle pulse qualifying rd_data.
REQ-010 Port empty, output, 1 bit, is high when count == 0.
REQ-011 Port full, output, 1 bit, is high when count == DEPTH.
REQ-012 Port count, output, clog2(DEPTH)+1 bits, is the number of stored entries.
REQ-013 Port overflow, output, 1 bit, is a sticky flag set when a result is dropped.
REQ-014 Port max_y, output, 8 bits, is the largest y captured since reset.

Function
REQ-015 The block SHALL register b into b_prev every cycle; a capture event SHALL be b_prev == 1 and b == 0 in the same cycle.
REQ-016 On a capture event with count < DEPTH, the block SHALL write {s, y} as sampled in that cycle to mem[wr_ptr], then increment wr_ptr (modulo DEPTH) and count.
REQ-017 A read is accepted when rd_en == 1 and count > 0; the block SHALL then register mem[rd_ptr] into rd_data at the next edge, assert rd_valid for exactly that one cycle, and increment rd_ptr (modulo DEPTH).
REQ-018 rd_en with count == 0 SHALL be ignored: no pointer change, rd_valid stays 0, and rd_data holds its previous value.
REQ-019 When a capture and an accepted read occur in the same cycle, both SHALL take effect and count SHALL be unchanged; this includes the full case, where the write is accepted.
REQ-020 A simultaneous capture and read request while empty SHALL perform the write only; the read is ignored, and the new entry is readable from the next cycle (no fall-through).
REQ-021 A capture event while full without an accepted read SHALL drop the result, leave the FIFO unchanged, and set overflow to 1 until reset.
REQ-022 Pointers SHALL be clog2(DEPTH) bits and wrap naturally; full and empty SHALL be derived from count only.
REQ-023 On every accepted capture, max_y SHALL be updated to y when y > max_y (unsigned compare); dropped results SHALL NOT update max_y.
REQ-024 empty, full and count SHALL reflect the state after the most recent edge, with no combinational path from rd_en or b.
REQ-025 rd_data SHALL remain stable between accepted reads.

Reset
REQ-026 While rst is high, the block SHALL asynchronously force:
- wr_ptr, rd_ptr, count to 0
- b_prev, rd_valid, overflow to 0
- rd_data and max_y to 0
- empty to 1, full to 0
REQ-027 Memory contents need not be cleared, but SHALL never be visible on rd_data before a write.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries.
REQ-029 After release, a b already high SHALL produce a capture only on its subsequent fall.

Verification
REQ-030 Reset and single capture: rst=1 for 2 cycles, then y=5, s=3, b 1->0 -> count=1, empty=0; rd_en one cycle -> next cycle rd_data=0x305, rd_valid=1 for one cycle, empty=1.
REQ-031 Fill and overflow: four captures y=10, 20, 30, 40 -> full=1, count=4; a fifth capture y=50 -> overflow=1, count=4, max_y=40; four reads return 10, 20, 30, 40 in order.
REQ-032 Simultaneous events at full: full FIFO, capture y=99 with rd_en=1 in the same cycle -> count stays 4, overflow stays 0, oldest entry returned, y=99 read last.
REQ-033 Empty read: rd_en=1 for 3 cycles with count=0 -> rd_valid=0 and rd_data unchanged; a capture during the third cycle -> count=1, and no rd_valid that cycle.
REQ-034 Wrap-around: 10 interleaved capture/read pairs with y=1..10 -> data returned in order, count never exceeds 1, pointers wrap without error, max_y=10.
REQ-035 Mid-operation reset: count=3, overflow=1, then pulse rst asynchronously between edges -> count=0, empty=1, overflow=0, max_y=0 immediately, with no rd_valid.
